spi_axi_frame: RTL and testbench

- SPI slave front end of the SPI-to-AXI bridge, directly upstream of the AXI master interface stage.
- Samples the asynchronous SPI pins in the aclk domain and assembles 16-bit words. Decodes each CS frame as a write or read command.
- Write frames produce a write strobe with a 12-bit word address and 32-bit data. Read frames produce a read strobe, then shift the returned 32-bit read data out on MISO.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first.

---
 rtl/spi_axi_frame.sv | 169 ++++++++++++++++
 tb/tb_spi_axi_frame.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_axi_frame.sv
// SPI mode-0 slave front end: synchronises the SPI pins into aclk, assembles 16-bit words and
// decodes each CS frame into an AXI write/read request; read data is shifted back on MISO.
module spi_axi_frame #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_WIDTH  = 12
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  spi_sck,
    input  logic                  spi_csn,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    output logic [ADDR_WIDTH-1:0] axi_wr_addr,
    output logic [31:0]           axi_wr_data,
    output logic                  axi_wr_en,
    output logic [ADDR_WIDTH-1:0] axi_rd_addr,
    output logic                  axi_rd_en,
    input  logic [31:0]           axi_rd_data,
    output logic                  stat_frame_err
);

    typedef enum logic [2:0] {
        StIdle, StCmd, StWrH, StWrL, StRdDummy, StRdH, StRdL, StDrain
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sck_sync_q, csn_sync_q, mosi_sync_q;
    logic                   sck_hist_q, csn_hist_q;
    logic                   sck_s, csn_s, mosi_s;
    logic                   capture, launch, csn_fall, csn_rise, active, word_done;
    logic [3:0]             bitcnt_q;
    logic [14:0]            rx_q;
    logic [15:0]            rx_next;
    logic [31:0]            tx_q;
    logic                   load_pend_q;
    logic [ADDR_WIDTH-1:0]  cmd_addr_q, wr_addr_q, rd_addr_q;
    logic [15:0]            data_hi_q;
    logic [31:0]            wr_data_q;
    logic                   wr_en_q, rd_en_q, frame_err_q;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign csn_s  = csn_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    always_comb begin
        capture   = sck_s & ~sck_hist_q & ~csn_s;
        launch    = ~sck_s & sck_hist_q & ~csn_s;
        csn_fall  = csn_hist_q & ~csn_s;
        csn_rise  = ~csn_hist_q & csn_s;
        active    = (state_q != StIdle);
        rx_next   = {rx_q, mosi_s};
        word_done = active & capture & (bitcnt_q == 4'd15);
    end

    always_comb begin
        state_d = state_q;
        if (csn_rise) begin
            state_d = StIdle;
        end else if (!active) begin
            if (csn_fall) state_d = StCmd;
        end else if (word_done) begin
            case (state_q)
                StCmd: begin
                    if (rx_next[13:12] == 2'b11)      state_d = StWrH;
                    else if (rx_next[13:12] == 2'b10) state_d = StRdDummy;
                    else                              state_d = StDrain;
                end
                StWrH:     state_d = StWrL;
                StWrL:     state_d = StDrain;
                StRdDummy: state_d = StRdH;
                StRdH:     state_d = StRdL;
                StRdL:     state_d = StDrain;
                default:   state_d = state_q;
            endcase
        end
    end

    // csn sync flops reset low so a frame in progress across reset never looks like a new start
    always_ff @(posedge aclk) begin
        if (areset) begin
            sck_sync_q  <= '0;
            csn_sync_q  <= '0;
            mosi_sync_q <= '0;
            sck_hist_q  <= 1'b0;
            csn_hist_q  <= 1'b0;
            state_q     <= StIdle;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sck_hist_q  <= sck_s;
            csn_hist_q  <= csn_s;
            state_q     <= state_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            bitcnt_q    <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            load_pend_q <= 1'b0;
            cmd_addr_q  <= '0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            data_hi_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
            if (csn_rise) begin
                frame_err_q <= (bitcnt_q != 4'd0);
                bitcnt_q    <= '0;
                rx_q        <= '0;
                tx_q        <= '0;
                load_pend_q <= 1'b0;
            end else if (active) begin
                if (capture) begin
                    rx_q     <= rx_next[14:0];
                    bitcnt_q <= bitcnt_q + 4'd1;
                end
                if (word_done) begin
                    case (state_q)
                        StCmd: begin
                            cmd_addr_q <= rx_next[ADDR_WIDTH-1:0];
                            if (rx_next[13:12] == 2'b10) begin
                                rd_addr_q <= rx_next[ADDR_WIDTH-1:0];
                                rd_en_q   <= 1'b1;
                            end
                        end
                        StWrH: data_hi_q <= rx_next;
                        StWrL: begin
                            wr_addr_q <= cmd_addr_q;
                            wr_data_q <= {data_hi_q, rx_next};
                            wr_en_q   <= 1'b1;
                        end
                        StRdDummy: load_pend_q <= 1'b1;
                        default: ;
                    endcase
                end
                // Zero-fill shifting leaves tx_q clear once all 32 read bits have gone out
                if (launch) begin
                    if (load_pend_q) begin
                        tx_q        <= axi_rd_data;
                        load_pend_q <= 1'b0;
                    end else begin
                        tx_q <= {tx_q[30:0], 1'b0};
                    end
                end
            end
        end
    end

    assign spi_miso       = tx_q[31];
    assign spi_miso_oe    = ~csn_s & active;
    assign axi_wr_addr    = wr_addr_q;
    assign axi_wr_data    = wr_data_q;
    assign axi_wr_en      = wr_en_q;
    assign axi_rd_addr    = rd_addr_q;
    assign axi_rd_en      = rd_en_q;
    assign stat_frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_axi_frame.sv
// Scoreboard bench for spi_axi_frame: expected AXI strobes are queued per frame and checked by a
// monitor; MISO words and frame-error counts are compared against hand-computed values.
module tb_spi_axi_frame;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_csn = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe;
    logic [11:0] axi_wr_addr, axi_rd_addr;
    logic [31:0] axi_wr_data;
    logic        axi_wr_en, axi_rd_en;
    logic [31:0] axi_rd_data = 32'h0;
    logic        stat_frame_err;

    spi_axi_frame #(.SYNC_STAGES(2), .ADDR_WIDTH(12)) dut (
        .aclk           (aclk),
        .areset         (areset),
        .spi_sck        (spi_sck),
        .spi_csn        (spi_csn),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso),
        .spi_miso_oe    (spi_miso_oe),
        .axi_wr_addr    (axi_wr_addr),
        .axi_wr_data    (axi_wr_data),
        .axi_wr_en      (axi_wr_en),
        .axi_rd_addr    (axi_rd_addr),
        .axi_rd_en      (axi_rd_en),
        .axi_rd_data    (axi_rd_data),
        .stat_frame_err (stat_frame_err)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic        is_wr;
        logic [11:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          err_cnt = 0;
    logic [31:0] rd_ret = 32'h0;
    logic [15:0] tx_words[4];
    logic [15:0] rx_words[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge aclk);
    endtask

    // Master: MISO is sampled just as SCK rises, MOSI changes while SCK is low
    task automatic spi_word(input logic [15:0] w, input int nb, input int half,
                            output logic [15:0] r);
        r = 16'h0;
        for (int b = 0; b < nb; b++) begin
            spi_mosi = w[15-b];
            cyc(half);
            r[15-b] = spi_miso;
            spi_sck = 1'b1;
            cyc(half);
            spi_sck = 1'b0;
        end
    endtask

    task automatic spi_frame(input int nw, input int partial, input int half);
        logic [15:0] r;
        spi_csn = 1'b0;
        cyc(half);
        for (int w = 0; w < 4; w++) rx_words[w] = 16'h0;
        for (int w = 0; w < nw; w++) begin
            spi_word(tx_words[w], 16, half, r);
            rx_words[w] = r;
        end
        if (partial > 0) spi_word(tx_words[nw], partial, half, r);
        cyc(half);
        spi_csn = 1'b1;
        spi_mosi = 1'b0;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input int half);
        exp_q.push_back({1'b1, a, d});
        tx_words[0] = {4'h3, a};
        tx_words[1] = d[31:16];
        tx_words[2] = d[15:0];
        spi_frame(3, 0, half);
    endtask

    task automatic do_read(input logic [11:0] a, input logic [31:0] d, input int half);
        rd_ret = d;
        axi_rd_data = 32'h0;
        exp_q.push_back({1'b0, a, 32'h0});
        tx_words[0] = {4'h2, a};
        tx_words[1] = 16'h0;
        tx_words[2] = 16'h0;
        tx_words[3] = 16'h0;
        spi_frame(4, 0, half);
        chk("miso_word1", {16'h0, rx_words[1]}, 32'h0);
        chk("miso_word2", {16'h0, rx_words[2]}, {16'h0, d[31:16]});
        chk("miso_word3", {16'h0, rx_words[3]}, {16'h0, d[15:0]});
    endtask

    // AXI stage model: returns rd_ret five cycles after each read strobe
    always begin
        @(negedge aclk);
        if (axi_rd_en && !areset) begin
            repeat (5) @(posedge aclk);
            axi_rd_data = rd_ret;
        end
    end

    // Monitor: pops the scoreboard on every strobe
    always @(negedge aclk) begin
        if (!areset) begin
            if (axi_wr_en || axi_rd_en) begin
                chk("wr_rd_exclusive", {31'h0, axi_wr_en & axi_rd_en}, 32'h0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_strobe: got wr=%0b rd=%0b, expected none",
                             axi_wr_en, axi_rd_en);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("strobe_kind", {31'h0, axi_wr_en}, {31'h0, e.is_wr});
                    if (e.is_wr) begin
                        chk("wr_addr", {20'h0, axi_wr_addr}, {20'h0, e.addr});
                        chk("wr_data", axi_wr_data, e.data);
                    end else begin
                        chk("rd_addr", {20'h0, axi_rd_addr}, {20'h0, e.addr});
                    end
                end
            end
            if (stat_frame_err) err_cnt++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_miso"}, {31'h0, spi_miso}, 32'h0);
        chk({tag, "_oe"}, {31'h0, spi_miso_oe}, 32'h0);
        chk({tag, "_wr_en"}, {31'h0, axi_wr_en}, 32'h0);
        chk({tag, "_rd_en"}, {31'h0, axi_rd_en}, 32'h0);
        chk({tag, "_wr_addr"}, {20'h0, axi_wr_addr}, 32'h0);
        chk({tag, "_wr_data"}, axi_wr_data, 32'h0);
        chk({tag, "_rd_addr"}, {20'h0, axi_rd_addr}, 32'h0);
        chk({tag, "_frame_err"}, {31'h0, stat_frame_err}, 32'h0);
    endtask

    initial begin
        logic [15:0] r;
        cyc(5);
        areset = 1'b0;
        cyc(5);
        chk_all_zero("reset");

        // Write frame at SCK = aclk/10
        do_write(12'h123, 32'hDEADBEEF, 5);
        cyc(10);
        chk("wr_addr_hold", {20'h0, axi_wr_addr}, 32'h123);
        chk("wr_data_hold", axi_wr_data, 32'hDEADBEEF);

        // Read frame
        do_read(12'h045, 32'hCAFEF00D, 5);
        cyc(10);

        // No-op command: no strobes, MISO idle
        tx_words[0] = 16'h0ABC;
        tx_words[1] = 16'h1234;
        tx_words[2] = 16'h5678;
        spi_frame(3, 0, 5);
        cyc(10);
        chk("noop_miso0", {16'h0, rx_words[0]}, 32'h0);
        chk("noop_miso1", {16'h0, rx_words[1]}, 32'h0);
        chk("noop_miso2", {16'h0, rx_words[2]}, 32'h0);
        chk("noop_frame_err", err_cnt, 0);

        // Aborted write after 7 bits of word2
        tx_words[0] = 16'h3055;
        tx_words[1] = 16'hAAAA;
        tx_words[2] = 16'h5555;
        spi_frame(2, 7, 5);
        cyc(10);
        chk("abort_frame_err", err_cnt, 1);
        chk("abort_wr_addr_hold", {20'h0, axi_wr_addr}, 32'h123);
        do_write(12'h001, 32'h00000001, 5);
        cyc(10);

        // Reset in the middle of word1 of a read frame
        rd_ret = 32'h0;
        exp_q.push_back({1'b0, 12'h045, 32'h0});
        spi_csn = 1'b0;
        cyc(5);
        spi_word(16'h2045, 16, 5, r);
        spi_word(16'h0000, 5, 5, r);
        chk("mid_frame_oe", {31'h0, spi_miso_oe}, 32'h1);
        areset = 1'b1;
        @(posedge aclk);
        #1;
        chk_all_zero("midreset");
        @(negedge aclk);
        areset = 1'b0;
        spi_word(16'h0000, 11, 5, r);
        spi_word(16'h0000, 16, 5, r);
        spi_word(16'h0000, 16, 5, r);
        cyc(5);
        spi_csn = 1'b1;
        cyc(10);
        chk("post_reset_rd_addr", {20'h0, axi_rd_addr}, 32'h0);
        chk("post_reset_frame_err", err_cnt, 1);
        do_read(12'h045, 32'hCAFEF00D, 5);
        cyc(10);

        // Back-to-back write then read at minimum SCK, 2-cycle CS gap
        do_write(12'h456, 32'h12345678, 4);
        cyc(2);
        do_read(12'h789, 32'h89ABCDEF, 4);
        cyc(20);
        chk("b2b_frame_err", err_cnt, 1);
        chk("b2b_rd_addr", {20'h0, axi_rd_addr}, 32'h789);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
